// File: rtl/clock_gate_controller_if.sv
// Handshake bundle between datapath requesters and the clock gate controller.
// The master drives activity/force; the slave (controller) returns gating status.
interface clock_gate_controller_if #(
    parameter int NUM_CH = 4,
    parameter int STAT_W = 16
);
    logic [NUM_CH-1:0] act_req;
    logic              force_on;
    logic [NUM_CH-1:0] gate_en;
    logic [NUM_CH-1:0] ready;
    logic              all_gated;
    logic [STAT_W-1:0] gated_stat;

    modport master (
        output act_req,
        output force_on,
        input  gate_en,
        input  ready,
        input  all_gated,
        input  gated_stat
    );

    modport slave (
        input  act_req,
        input  force_on,
        output gate_en,
        output ready,
        output all_gated,
        output gated_stat
    );
endinterface

// File: rtl/clock_gate_controller.sv
// Per-channel idle-timeout sequencer: gates a channel's clock after a run of idle
// cycles and holds ready low for a fixed settle time when the channel wakes up.
module clock_gate_controller #(
    parameter int NUM_CH      = 4,
    parameter int IDLE_CYCLES = 8,
    parameter int WAKE_CYCLES = 2,
    parameter int CNT_W       = 4,
    parameter int STAT_W      = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    clock_gate_controller_if.slave  bus
);
    localparam logic [1:0] ST_RUN  = 2'd0;
    localparam logic [1:0] ST_IDLE = 2'd1;
    localparam logic [1:0] ST_OFF  = 2'd2;
    localparam logic [1:0] ST_WAKE = 2'd3;

    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_CYCLES - 1);
    localparam int               SUM_W     = STAT_W + 5;
    localparam logic [SUM_W-1:0] STAT_MAX  = SUM_W'({STAT_W{1'b1}});

    logic [NUM_CH-1:0] off_now;
    logic [NUM_CH-1:0] off_next;
    logic [NUM_CH-1:0] live_next;

    logic [NUM_CH-1:0] gate_en_reg;
    logic [NUM_CH-1:0] ready_reg;
    logic              all_gated_reg;
    logic [STAT_W-1:0] gated_stat_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [1:0]       state_reg;
            logic [1:0]       state_next;
            logic [CNT_W-1:0] cnt_reg;
            logic [CNT_W-1:0] cnt_next;
            logic             wake_req;

            assign wake_req = bus.force_on | bus.act_req[gi];

            always_comb begin
                state_next = state_reg;
                cnt_next   = cnt_reg;
                case (state_reg)
                    ST_RUN: begin
                        if (!wake_req) begin
                            state_next = ST_IDLE;
                            cnt_next   = CNT_W'(1);
                        end
                    end
                    ST_IDLE: begin
                        if (wake_req) begin
                            state_next = ST_RUN;
                            cnt_next   = '0;
                        end else if (cnt_reg == IDLE_LAST) begin
                            state_next = ST_OFF;
                            cnt_next   = '0;
                        end else begin
                            cnt_next = cnt_reg + CNT_W'(1);
                        end
                    end
                    ST_OFF: begin
                        if (wake_req) begin
                            state_next = ST_WAKE;
                            cnt_next   = '0;
                        end
                    end
                    default: begin
                        // Settling is never cut short, whatever the inputs do.
                        if (cnt_reg == WAKE_LAST) begin
                            state_next = ST_RUN;
                            cnt_next   = '0;
                        end else begin
                            cnt_next = cnt_reg + CNT_W'(1);
                        end
                    end
                endcase
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    state_reg <= ST_RUN;
                    cnt_reg   <= '0;
                end else begin
                    state_reg <= state_next;
                    cnt_reg   <= cnt_next;
                end
            end

            assign off_now[gi]   = (state_reg == ST_OFF);
            assign off_next[gi]  = (state_next == ST_OFF);
            assign live_next[gi] = (state_next == ST_RUN) || (state_next == ST_IDLE);
        end
    endgenerate

    function automatic logic [4:0] popcount(input logic [NUM_CH-1:0] v);
        logic [4:0] c;
        c = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            c = c + 5'(v[i]);
        end
        return c;
    endfunction

    logic [SUM_W-1:0] stat_sum;
    assign stat_sum = SUM_W'(gated_stat_reg) + SUM_W'(popcount(off_now));

    // The statistic is charged on the edge that closes each OFF cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            gate_en_reg    <= '1;
            ready_reg      <= '1;
            all_gated_reg  <= 1'b0;
            gated_stat_reg <= '0;
        end else begin
            gate_en_reg    <= ~off_next;
            ready_reg      <= live_next;
            all_gated_reg  <= &off_next;
            gated_stat_reg <= (stat_sum > STAT_MAX) ? STAT_MAX[STAT_W-1:0]
                                                    : stat_sum[STAT_W-1:0];
        end
    end

    assign bus.gate_en    = gate_en_reg;
    assign bus.ready      = ready_reg;
    assign bus.all_gated  = all_gated_reg;
    assign bus.gated_stat = gated_stat_reg;
endmodule

// File: tb/tb_clock_gate_controller.sv
// Directed bench for clock_gate_controller: default instance plus a narrow-statistic
// instance to exercise saturation.
module tb_clock_gate_controller;
    logic clk = 1'b0;
    logic reset = 1'b1;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    clock_gate_controller_if #(.NUM_CH(4), .STAT_W(16)) bus ();
    clock_gate_controller_if #(.NUM_CH(4), .STAT_W(4))  bus_sat ();

    clock_gate_controller #(
        .NUM_CH(4), .IDLE_CYCLES(8), .WAKE_CYCLES(2), .CNT_W(4), .STAT_W(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.slave)
    );

    clock_gate_controller #(
        .NUM_CH(4), .IDLE_CYCLES(8), .WAKE_CYCLES(2), .CNT_W(4), .STAT_W(4)
    ) dut_sat (
        .clk(clk),
        .reset(reset),
        .bus(bus_sat.slave)
    );

    task automatic check_val(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end else begin
            $display("[TB] ok %s = 0x%0h", tag, actual);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic [3:0] g, input logic [3:0] r,
                              input logic ag);
        check_val({tag, " gate_en"}, 32'(bus.gate_en), 32'(g));
        check_val({tag, " ready"}, 32'(bus.ready), 32'(r));
        check_val({tag, " all_gated"}, 32'(bus.all_gated), 32'(ag));
    endtask

    initial begin
        bus.act_req      = 4'h0;
        bus.force_on     = 1'b0;
        bus_sat.act_req  = 4'h0;
        bus_sat.force_on = 1'b0;

        // Reset held two edges, then everything idle.
        tick();
        check_outs("rst", 4'hF, 4'hF, 1'b0);
        check_val("rst stat", 32'(bus.gated_stat), 32'd0);
        tick();
        reset = 1'b0;
        for (int e = 1; e <= 13; e++) begin
            tick();
            if (e == 7) check_outs("idle7", 4'hF, 4'hF, 1'b0);
            if (e == 8) begin
                check_outs("idle8", 4'h0, 4'h0, 1'b1);
                check_val("idle8 stat", 32'(bus.gated_stat), 32'd0);
            end
            if (e == 9)  check_val("stat e9", 32'(bus.gated_stat), 32'd4);
            if (e == 10) check_val("stat e10", 32'(bus.gated_stat), 32'd8);
            if (e == 9)  check_val("sat e9", 32'(bus_sat.gated_stat), 32'd4);
            if (e == 10) check_val("sat e10", 32'(bus_sat.gated_stat), 32'd8);
            if (e == 11) check_val("sat e11", 32'(bus_sat.gated_stat), 32'd12);
            if (e == 12) check_val("sat e12", 32'(bus_sat.gated_stat), 32'd15);
            if (e == 13) check_val("sat e13", 32'(bus_sat.gated_stat), 32'd15);
        end

        // force_on wakes every channel and blocks gating while held.
        bus.force_on = 1'b1;
        tick();
        check_outs("force1", 4'hF, 4'h0, 1'b0);
        tick();
        check_outs("force2", 4'hF, 4'h0, 1'b0);
        tick();
        check_outs("force3", 4'hF, 4'hF, 1'b0);
        for (int i = 0; i < 17; i++) tick();
        check_outs("force20", 4'hF, 4'hF, 1'b0);
        bus.force_on = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        check_outs("unforce7", 4'hF, 4'hF, 1'b0);
        tick();
        check_outs("unforce8", 4'h0, 4'h0, 1'b1);

        // Reset while ch2 is mid-wake (cnt=1) and the rest are OFF.
        bus.act_req = 4'b0100;
        tick();
        check_outs("wake2 a", 4'b0100, 4'h0, 1'b0);
        bus.act_req = 4'h0;
        tick();
        check_outs("wake2 b", 4'b0100, 4'h0, 1'b0);
        reset = 1'b1;
        tick();
        check_outs("midrst", 4'hF, 4'hF, 1'b0);
        check_val("midrst stat", 32'(bus.gated_stat), 32'd0);
        reset = 1'b0;

        // Ch0 idles 7 edges, one active edge restarts its timeout.
        bus.act_req = 4'b1110;
        for (int i = 0; i < 7; i++) tick();
        check_outs("ch0 idle7", 4'hF, 4'hF, 1'b0);
        bus.act_req = 4'hF;
        tick();
        bus.act_req = 4'b1110;
        for (int i = 0; i < 7; i++) tick();
        check_outs("ch0 re7", 4'hF, 4'hF, 1'b0);
        tick();
        check_outs("ch0 re8", 4'b1110, 4'b1110, 1'b0);

        // Everything OFF, then ch1 woken by its own request.
        bus.act_req = 4'h0;
        for (int i = 0; i < 8; i++) tick();
        check_outs("alloff", 4'h0, 4'h0, 1'b1);
        bus.act_req = 4'b0010;
        tick();
        check_outs("ch1 N", 4'b0010, 4'h0, 1'b0);
        tick();
        check_outs("ch1 N+1", 4'b0010, 4'h0, 1'b0);
        tick();
        check_outs("ch1 N+2", 4'b0010, 4'b0010, 1'b0);
        for (int i = 0; i < 10; i++) tick();
        check_outs("ch1 hold", 4'b0010, 4'b0010, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
